// File: rtl/fact_job_sched.sv
// Two-requester job scheduler in front of a factorial accelerator.
// Round-robin arbitration, operand range check, completion timeout and result capture.
module fact_job_sched #(
    parameter logic [15:0] TMO_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [3:0]  n0,
    input  logic        req1,
    input  logic [3:0]  n1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        fact_go,
    output logic [3:0]  fact_n,
    input  logic        fact_done,
    input  logic [31:0] fact_result,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] res_value,
    output logic        res_owner,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REJECT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        last_owner;
    logic [15:0] tmo_cnt;
    logic        sel_valid;
    logic        sel_idx;
    logic [3:0]  sel_n;
    logic        tmo_hit;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        sel_valid = req0 | req1;
        sel_idx   = (req0 && req1) ? ~last_owner : req1;
        sel_n     = sel_idx ? n1 : n0;
        tmo_hit   = (tmo_cnt == TMO_CYCLES - 16'd1);
    end

    always_comb begin
        state_d = state;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        fact_go = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_d = (sel_n > 4'd12) ? REJECT : LAUNCH;
                end
            end
            LAUNCH: begin
                fact_go = 1'b1;
                gnt0    = ~res_owner;
                gnt1    = res_owner;
                state_d = WAIT;
            end
            WAIT: begin
                if (fact_done || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            REJECT: begin
                gnt0    = ~res_owner;
                gnt1    = res_owner;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // busy also covers the cycle in which a finished job's result is first presented.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= 1'b1;
            fact_n     <= 4'd0;
            res_valid  <= 1'b0;
            res_value  <= 32'd0;
            res_owner  <= 1'b0;
            err        <= 1'b0;
            tmo_cnt    <= 16'd0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_d != IDLE) || (state != IDLE);
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        last_owner <= sel_idx;
                        fact_n     <= sel_n;
                        res_valid  <= 1'b0;
                        err        <= 1'b0;
                        res_owner  <= sel_idx;
                    end
                end
                LAUNCH: tmo_cnt <= 16'd0;
                WAIT: begin
                    if (!fact_done) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                    // Completion wins over a timeout landing in the same cycle.
                    if (fact_done) begin
                        res_value <= fact_result;
                        res_valid <= 1'b1;
                        err       <= 1'b0;
                    end else if (tmo_hit) begin
                        res_value <= 32'd0;
                        res_valid <= 1'b1;
                        err       <= 1'b1;
                    end
                end
                REJECT: begin
                    res_value <= 32'd0;
                    res_valid <= 1'b1;
                    err       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_job_sched.sv
// Bench for fact_job_sched: accelerator model, grant/result scoreboards and directed job scenarios.
// Handshake: a job is offered by holding reqN; it is taken on the gnt pulse, the result is announced by res_valid rising.
module tb_fact_job_sched;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [3:0]  n0;
    logic        req1;
    logic [3:0]  n1;
    logic        gnt0;
    logic        gnt1;
    logic        fact_go;
    logic [3:0]  fact_n;
    logic        fact_done;
    logic [31:0] fact_result;
    logic        busy;
    logic        res_valid;
    logic [31:0] res_value;
    logic        res_owner;
    logic        err;

    fact_job_sched #(.TMO_CYCLES(16'd16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .n0         (n0),
        .req1       (req1),
        .n1         (n1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .fact_go    (fact_go),
        .fact_n     (fact_n),
        .fact_done  (fact_done),
        .fact_result(fact_result),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_value  (res_value),
        .res_owner  (res_owner),
        .err        (err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [33:0] exp_q[$];
    logic        gnt_q[$];

    int  acc_delay = 3;
    bit  acc_hang  = 1'b0;
    int  go_cnt    = 0;
    logic prev_rv  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fact_of(input logic [3:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    // Accelerator model: answers acc_delay rising edges after seeing fact_go.
    initial begin
        logic [3:0] acc_n;
        fact_done   = 1'b0;
        fact_result = 32'd0;
        forever begin
            @(negedge clk);
            if (fact_go === 1'b1 && !acc_hang) begin
                acc_n = fact_n;
                repeat (acc_delay) @(posedge clk);
                #1;
                fact_done   = 1'b1;
                fact_result = fact_of(acc_n);
                @(posedge clk);
                #1;
                fact_done   = 1'b0;
                fact_result = 32'hdead_beef;
            end
        end
    end

    // Scoreboard monitors
    always @(negedge clk) begin
        if (fact_go === 1'b1) go_cnt++;
        if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
            check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
            check("gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
            if (gnt_q.size() != 0) check("gnt_owner", 64'(gnt1), 64'(gnt_q.pop_front()));
        end
        if (res_valid === 1'b1 && !prev_rv) begin
            check("res_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("res_owner_err_value", 64'({res_owner, err, res_value}), 64'(exp_q.pop_front()));
        end
        prev_rv = (res_valid === 1'b1);
    end

    // Driver tasks
    task automatic do_reset(input int cyc);
        @(negedge clk);
        rst = 1'b0;
        repeat (cyc) @(negedge clk);
        rst = 1'b1;
    endtask

    // Returns posedges counted after LAUNCH ends until res_valid is seen (-1 on timeout).
    task automatic wait_res(input string name, output int cyc);
        cyc = -1;
        @(posedge clk);
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (res_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check(name, 64'(cyc > 0), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    initial begin
        int cyc;
        int g;
        int busy_cnt;
        int go0;

        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        n0   = 4'd0;
        n1   = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_strobes", 64'({gnt0, gnt1, fact_go, busy}), 64'd0);
        check("rst_status", 64'({res_valid, err, res_owner}), 64'd0);
        check("rst_fact_n", 64'(fact_n), 64'd0);
        check("rst_res_value", 64'(res_value), 64'd0);
        rst = 1'b1;

        // Single job: 5! with a 10-cycle accelerator.
        acc_delay = 10;
        @(negedge clk);
        req0 = 1'b1; n0 = 4'd5;
        gnt_q.push_back(1'b0);
        exp_q.push_back({1'b0, 1'b0, 32'd120});
        @(negedge clk);
        check("t1_gnt0", 64'(gnt0), 64'd1);
        check("t1_fact_go", 64'(fact_go), 64'd1);
        check("t1_fact_n", 64'(fact_n), 64'd5);
        req0 = 1'b0;
        wait_res("t1_res_seen", cyc);
        check("t1_done_cycles", 64'(cyc), 64'd10);
        @(posedge clk);
        #1;
        check("t1_busy_next", 64'(busy), 64'd0);

        // Tie after reset: requester 0 first, then alternate.
        do_reset(2);
        acc_delay = 3;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; n0 = 4'd3; n1 = 4'd4;
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        exp_q.push_back({1'b0, 1'b0, 32'd6});
        exp_q.push_back({1'b1, 1'b0, 32'd24});
        exp_q.push_back({1'b0, 1'b0, 32'd6});
        exp_q.push_back({1'b1, 1'b0, 32'd24});
        g = 0;
        for (int i = 0; i < 300 && g < 4; i++) begin
            @(negedge clk);
            if (gnt0 === 1'b1 || gnt1 === 1'b1) g++;
        end
        check("t2_grant_count", 64'(g), 64'd4);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle("t2_idle");

        // Operand overflow: 13 is rejected without launching.
        @(negedge clk);
        req1 = 1'b1; n1 = 4'd13;
        gnt_q.push_back(1'b1);
        exp_q.push_back({1'b1, 1'b1, 32'd0});
        go0 = go_cnt;
        @(negedge clk);
        check("t3_gnt1", 64'(gnt1), 64'd1);
        check("t3_fact_go", 64'(fact_go), 64'd0);
        req1 = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        check("t3_busy_cycles", 64'(busy_cnt), 64'd2);
        check("t3_no_launch", 64'(go_cnt - go0), 64'd0);

        // Timeout: accelerator never answers, abort after 16 WAIT cycles.
        acc_hang = 1'b1;
        @(negedge clk);
        req0 = 1'b1; n0 = 4'd6;
        gnt_q.push_back(1'b0);
        exp_q.push_back({1'b0, 1'b1, 32'd0});
        @(negedge clk);
        check("t4_gnt0", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        wait_res("t4_res_seen", cyc);
        check("t4_tmo_cycles", 64'(cyc), 64'd16);
        acc_hang  = 1'b0;
        acc_delay = 4;
        @(negedge clk);
        req0 = 1'b1; n0 = 4'd12;
        gnt_q.push_back(1'b0);
        exp_q.push_back({1'b0, 1'b0, 32'd479001600});
        @(negedge clk);
        check("t4b_gnt0", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        wait_res("t4b_res_seen", cyc);

        // fact_done coincides with the last WAIT cycle: completion wins.
        acc_delay = 16;
        @(negedge clk);
        req1 = 1'b1; n1 = 4'd7;
        gnt_q.push_back(1'b1);
        exp_q.push_back({1'b1, 1'b0, 32'd5040});
        @(negedge clk);
        check("t5_gnt1", 64'(gnt1), 64'd1);
        req1 = 1'b0;
        wait_res("t5_res_seen", cyc);
        check("t5_done_cycles", 64'(cyc), 64'd16);

        // Reset in WAIT abandons the job; the late fact_done is ignored.
        acc_delay = 5;
        @(negedge clk);
        req1 = 1'b1; n1 = 4'd4;
        gnt_q.push_back(1'b1);
        @(negedge clk);
        check("t6_gnt1", 64'(gnt1), 64'd1);
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6_rst_strobes", 64'({gnt0, gnt1, fact_go, busy}), 64'd0);
        check("t6_rst_status", 64'({res_valid, err, res_owner}), 64'd0);
        check("t6_rst_fact_n", 64'(fact_n), 64'd0);
        check("t6_rst_res_value", 64'(res_value), 64'd0);
        repeat (8) @(negedge clk);
        check("t6_after_done", 64'({res_valid, err, busy}), 64'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size() + gnt_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
